// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage.
//   word_t        : 32-bit machine word
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one buffered instruction with its PC
//   align_word()  : clears the two byte-offset bits of an address
package fetch_unit_pkg;

    localparam int unsigned BIT_WIDTH  = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef logic [BIT_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StFlush
    } fetch_state_t;

    typedef struct packed {
        word_t                pc;
        logic [BIT_WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[BIT_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage signal bundle: instruction memory request/response, decode
// handshake, redirect input and fault output.
//   master : the fetch unit's view
//   slave  : the environment's view (memory, decode, execute)
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;
    logic  inst_valid;
    word_t inst;
    word_t inst_pc;
    logic  inst_ready;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  fetch_fault;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_ready, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_ready, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO of fetch_entry_t with a
// synchronous flush that takes priority over push/pop.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : empty the buffer at this edge
//   push, wdata   : write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   rdata         : head entry
//   count/full/empty : occupancy status
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    localparam ptr_t LastPtr = ptr_t'(DEPTH - 1);

    fetch_entry_t        mem_q [DEPTH];
    ptr_t                wr_ptr_q;
    ptr_t                rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                do_push;
    logic                do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastPtr) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, keeps at most one request
// outstanding to instruction memory, buffers returned words and hands
// {inst, pc} to decode. A redirect flushes buffered and in-flight work and
// restarts fetch at the new PC; an in-flight request is never withdrawn, so
// its response is absorbed in the FLUSH state.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_unit_if.master (imem_*, inst_*, redirect_*, fetch_fault)
// Build option FETCH_MISALIGN_CHECK_EN: a redirect to a non-word-aligned
// target raises a sticky fetch_fault and parks fetch in IDLE until the next
// aligned redirect. Without it the low target bits are dropped.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MisalignCheck = 1'b1;
`else
    localparam bit MisalignCheck = 1'b0;
`endif

    fetch_state_t    state_q;
    word_t           pc_q;
    word_t           addr_q;
    logic            fault_q;

    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [CntW-1:0] count;
    logic [CntW-1:0] count_next;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            full_after;
    logic            redir_bad;
    logic            fault_next;

    assign redir_bad  = MisalignCheck && (bus.redirect_pc[1:0] != 2'b00);
    assign fault_next = bus.redirect_valid ? redir_bad : fault_q;

    // A redirect kills both the incoming response and any decode pop.
    assign push = (state_q == StWait) && bus.imem_ready && !bus.redirect_valid;
    assign pop  = !empty && bus.inst_ready && !bus.redirect_valid;

    assign push_entry = '{pc: pc_q, inst: bus.imem_rdata};
    assign count_next = count + CntW'(push) - CntW'(pop);
    assign full_after = (count_next == CntW'(FIFO_DEPTH));

    fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_next;

            if (bus.redirect_valid) begin
                pc_q <= align_word(bus.redirect_pc);
            end else if (push) begin
                pc_q <= pc_q + word_t'(INST_BYTES);
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.redirect_valid) begin
                        state_q <= fault_next ? StIdle : StWait;
                    end else if (!fault_q && !full) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.redirect_valid) begin
                        if (bus.imem_ready) begin
                            state_q <= fault_next ? StIdle : StWait;
                        end else begin
                            // Keep presenting the old address until it completes.
                            addr_q  <= pc_q;
                            state_q <= StFlush;
                        end
                    end else if (bus.imem_ready) begin
                        state_q <= full_after ? StIdle : StWait;
                    end
                end
                StFlush: begin
                    if (bus.imem_ready) begin
                        state_q <= fault_next ? StIdle : StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_req    = (state_q != StIdle);
    assign bus.imem_addr   = (state_q == StFlush) ? addr_q : pc_q;
    assign bus.inst_valid  = !empty;
    assign bus.inst        = head.inst;
    assign bus.inst_pc     = head.pc;
    assign bus.fetch_fault = fault_q;

endmodule
